// File: rtl/alu_pkg.sv
// Shared op codes, flag positions and controller states
// for the sequential ALU and its controller.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_MVN = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_ASR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int Z_BIT = 3;
  localparam int V_BIT = 2;
  localparam int N_BIT = 1;
  localparam int C_BIT = 0;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU ops 000-110 with {Z,V,N,C} flag generation.
// Op 111 is handled by the sequential multiplier and yields zero here.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] asr;
  logic [WIDTH-1:0] asr1;
  logic             v;
  logic             c;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign dif  = {1'b0, a} - {1'b0, b};
  assign sh   = b[SHW-1:0];
  assign asr  = $signed(a) >>> sh;
  // one bit less of shift leaves the last bit shifted out in bit 0
  assign asr1 = $signed(a) >>> (sh - 1'b1);

  always_comb begin
    res = '0;
    v   = 1'b0;
    c   = 1'b0;
    unique case (1'b1)
      op == OP_ADD: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) &&
              (res[WIDTH-1] != a[WIDTH-1]);
      end
      op == OP_SUB: begin
        res = dif[WIDTH-1:0];
        c   = dif[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) &&
              (res[WIDTH-1] == b[WIDTH-1]);
      end
      op == OP_AND: res = a & b;
      op == OP_MVN: res = ~b;
      op == OP_OR:  res = a | b;
      op == OP_XOR: res = a ^ b;
      op == OP_ASR: begin
        res = asr;
        c   = (sh != '0) && asr1[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    flags        = '0;
    flags[Z_BIT] = (res == '0);
    flags[V_BIT] = v;
    flags[N_BIT] = res[WIDTH-1];
    flags[C_BIT] = c;
  end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU: single-cycle ops via alu_comb, plus an
// iterative shift-add multiplier sequenced by a 2-state FSM.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             upd_flags,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       status
);

  localparam int CW = SHW + 1;

  state_t             state;
  state_t             nxt;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] ash_q;
  logic [WIDTH-1:0]   mlt_q;
  logic [CW-1:0]      cnt_q;
  logic               upd_q;
  logic [2*WIDTH-1:0] acc_nx;
  logic [3:0]         pflg;
  logic [WIDTH-1:0]   cres;
  logic [3:0]         cflg;
  logic               go;
  logic               last;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a    (Ain),
    .b    (Bin),
    .op   (op),
    .res  (cres),
    .flags(cflg)
  );

  assign go     = start && (state == S_IDLE);
  assign last   = (state == S_MUL) && (cnt_q == CW'(1));
  assign busy   = (state == S_MUL);
  assign acc_nx = acc_q + (mlt_q[0] ? ash_q : '0);

  always_comb begin
    pflg        = '0;
    pflg[Z_BIT] = (acc_nx[WIDTH-1:0] == '0);
    pflg[V_BIT] = |acc_nx[2*WIDTH-1:WIDTH];
    pflg[N_BIT] = acc_nx[WIDTH-1];
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (go && op == OP_MUL) nxt = S_MUL;
      S_MUL:  if (last) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      ash_q  <= '0;
      mlt_q  <= '0;
      cnt_q  <= '0;
      upd_q  <= 1'b0;
      out    <= '0;
      status <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        if (op == OP_MUL) begin
          acc_q <= '0;
          ash_q <= {{WIDTH{1'b0}}, Ain};
          mlt_q <= Bin;
          cnt_q <= CW'(WIDTH);
          upd_q <= upd_flags;
        end else begin
          out  <= cres;
          done <= 1'b1;
          if (upd_flags) status <= cflg;
        end
      end else if (state == S_MUL) begin
        // ash_q tracks A << (WIDTH - count) one shift per step
        acc_q <= acc_nx;
        ash_q <= ash_q << 1;
        mlt_q <= mlt_q >> 1;
        cnt_q <= cnt_q - CW'(1);
        if (last) begin
          out  <= acc_nx[WIDTH-1:0];
          done <= 1'b1;
          if (upd_q) status <= pflg;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16).
// Inputs change 1 time unit after rising edges; outputs sampled there.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic        upd_flags;
  logic [15:0] Ain;
  logic [15:0] Bin;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic [3:0]  status;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .upd_flags(upd_flags),
    .Ain      (Ain),
    .Bin      (Bin),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .status   (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic uf);
    op = o; Ain = a; Bin = b; upd_flags = uf; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = OP_ADD;
    upd_flags = 1'b1; Ain = '0; Bin = '0;
    #2;
    chk("rst_out", out, 32'h0);
    chk("rst_status", status, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_done", done, 32'h0);
    #10 rst_n = 1'b1;
    step();

    issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b1);
    chk("add_ovf_done", done, 32'h1);
    chk("add_ovf_out", out, 32'h8000);
    chk("add_ovf_st", status, 32'h6);
    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b1);
    chk("add_cy_done", done, 32'h1);
    chk("add_cy_out", out, 32'h0000);
    chk("add_cy_st", status, 32'h9);
    step();
    chk("done_drop", done, 32'h0);
    chk("out_held", out, 32'h0000);

    issue(OP_SUB, 16'h0003, 16'h0005, 1'b1);
    chk("sub_out", out, 32'hFFFE);
    chk("sub_st", status, 32'h3);
    issue(OP_SUB, 16'h0005, 16'h0005, 1'b0);
    chk("cmp_nf_out", out, 32'h0000);
    chk("cmp_nf_st", status, 32'h3);

    issue(OP_ASR, 16'h8003, 16'h0002, 1'b1);
    chk("asr_out", out, 32'hE000);
    chk("asr_st", status, 32'h3);
    issue(OP_ASR, 16'h8003, 16'h0000, 1'b1);
    chk("asr0_out", out, 32'h8003);
    chk("asr0_st", status, 32'h2);
    issue(OP_MVN, 16'h1234, 16'h00FF, 1'b1);
    chk("mvn_out", out, 32'hFF00);
    step();

    issue(OP_MUL, 16'h0012, 16'h0034, 1'b1);
    chk("mul_busy0", busy, 32'h1);
    chk("mul_done0", done, 32'h0);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("mul_busy", busy, 32'h1);
      chk("mul_nodone", done, 32'h0);
      if (i == 5) begin
        op = OP_ADD; Ain = 16'h0001; Bin = 16'h0001; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    step();
    chk("mul_busy16", busy, 32'h0);
    chk("mul_done16", done, 32'h1);
    chk("mul_out", out, 32'h03A8);
    chk("mul_st", status, 32'h0);
    step();
    chk("mul_done_drop", done, 32'h0);

    issue(OP_MUL, 16'h0100, 16'h0100, 1'b1);
    wait_done("mul2_done");
    chk("mul2_out", out, 32'h0000);
    chk("mul2_st", status, 32'hC);

    op = OP_AND; Ain = 16'hF0F0; Bin = 16'hFF00;
    upd_flags = 1'b0; start = 1'b1;
    step();
    chk("b2b_and_done", done, 32'h1);
    chk("b2b_and_out", out, 32'hF000);
    op = OP_OR;
    step();
    chk("b2b_or_done", done, 32'h1);
    chk("b2b_or_out", out, 32'hFFF0);
    op = OP_XOR;
    step();
    start = 1'b0;
    chk("b2b_xor_done", done, 32'h1);
    chk("b2b_xor_out", out, 32'h0FF0);
    chk("b2b_st_kept", status, 32'hC);
    step();
    chk("b2b_done_drop", done, 32'h0);

    issue(OP_MUL, 16'h0003, 16'h0003, 1'b1);
    step();
    step();
    chk("mid_busy", busy, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_out", out, 32'h0);
    chk("rstm_status", status, 32'h0);
    chk("rstm_busy", busy, 32'h0);
    chk("rstm_done", done, 32'h0);
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_busy", busy, 32'h0);
    issue(OP_ADD, 16'h0002, 16'h0003, 1'b1);
    chk("post_rst_out", out, 32'h0005);
    chk("post_rst_st", status, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the datapath's single-cycle ALU. It takes operands with a start/done handshake and executes seven single-cycle operations plus an iterative shift-add multiply. Results and a 4-bit status flag set {Z, V, N, C} are held in registers. The block sits between the register-file read ports (Ain/Bin) and the writeback mux, and the controller FSM sequences it.

## Interface
- WIDTH, 16: operand/result width in bits, ≥ 4.
- SHW, $clog2(WIDTH): shift-amount width, derived; not overridden.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  3  operation code (see Operation)
- upd_flags  in  1  when 1, status register is written on completion
- Ain  in  WIDTH  operand A
- Bin  in  WIDTH  operand B
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse: out/status valid
- out  out  WIDTH  registered result, held until next completion
- status  out  4  registered {Z, V, N, C}

## Operation
- Op codes:
  - 000 ADD: A+B
  - 001 SUB/CMP: A−B
  - 010 AND
  - 011 MVN: ~B
  - 100 OR
  - 101 XOR
  - 110 ASR: A arithmetic-shift-right by Bin[SHW-1:0]
  - 111 MUL: unsigned A×B, low WIDTH bits to out
- Operands and op are captured into internal registers on an accepted start. Mid-operation changes on the inputs have no effect.
- Flags:
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - V:
    - ADD: operands have the same sign and the result sign differs.
    - SUB: operands have different signs and the result sign equals B's sign.
    - MUL: upper WIDTH product bits are nonzero.
    - Otherwise 0.
  - C:
    - ADD: carry out of bit WIDTH-1.
    - SUB: borrow, i.e. unsigned A<B.
    - ASR: last bit shifted out, 0 for a shift of 0.
    - Otherwise 0.
- FSM states:
  - IDLE:
    - start with op≠111: compute combinationally and register out/status. Assert done in the next cycle and remain in IDLE.
    - start with op=111: load the accumulator (2·WIDTH bits) = 0, the multiplier = B, and count = WIDTH. Go to MUL.
  - MUL: each cycle, if multiplier[0], add A<<(WIDTH−count) into the accumulator. Shift the multiplier right by one and decrement count. When count reaches 1, that cycle performs the final step, registers out/status, and returns to IDLE. done is asserted the following cycle.
- busy = 1 exactly while in MUL. start while busy is ignored, with no queuing.
- upd_flags=0: out is still written, status is unchanged.
- Reset values: state IDLE, out 0, status 0000, busy 0, done 0, counter 0.

## Timing
- Single-cycle ops: start sampled at edge k; out/status/done valid after edge k (latency 1). done deasserts after edge k+1 unless another start was accepted at edge k+1.
- Back-to-back single-cycle starts are accepted every cycle, and done stays high continuously.
- MUL: start at edge k; busy high after edge k through edge k+WIDTH; out/status/done valid after edge k+WIDTH (latency WIDTH).
- start in the cycle done is high is accepted (IDLE already reached).
- rst_n low at any time, including mid-MUL, immediately forces all reset values. There is no partial result.

## Structure
- Shared package alu_pkg:
  - op-code localparams OP_ADD…OP_MUL
  - flag index constants Z_BIT=3, V_BIT=2, N_BIT=1, C_BIT=0
  - state enum {S_IDLE, S_MUL}
- The controller FSM imports the same package.
- Sub-module alu_comb: purely combinational single-cycle ops and flag generation for ops 000–110, parametrised by WIDTH. alu_seq instantiates it and owns the FSM, operand registers, and the multiplier datapath.

## Test plan
- Reset: assert rst_n=0 mid-run. Response: out=0000, status=0000, busy=0, done=0, with no clock edge needed.
- ADD overflow/carry (WIDTH=16), A=7FFF, B=0001: out=8000, status {Z,V,N,C}=0110. Then A=FFFF, B=0001: out=0000, status=1001.
- SUB/CMP, A=0003, B=0005, upd_flags=1: out=FFFE, status=0011. Repeat with upd_flags=0 and A=B=0005: out=0000, status still 0011.
- ASR, A=8003, Bin=0002: out=E000, C=1, N=1. Shift of 0: out=A, C=0.
- MUL, A=0012, B=0034: busy for 16 cycles, done pulse at edge 16, out=03A8, V=0. A=B=0100: out=0000, Z=1, V=1. A start pulsed mid-MUL is ignored.
- Back-to-back: AND, OR, XOR starts on consecutive cycles with A=F0F0, B=FF00. done is high for 3 cycles; out sequence F000, FFF0, 0FF0.
